uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter OVERSAMPLE, default 16, ticks per bit period; legal values are powers of two from 8 to 16.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; 8N1 framing.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 baud_tick  input  1  oversample strobe, one clk cycle wide, OVERSAMPLE per bit period.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 shift_en  output  1  one-cycle pulse; downstream shift register loads sample_bit.
REQ-008 sample_bit  output  1  mid-bit sampled data value, valid while shift_en is 1.
REQ-009 bit_cnt  output  4  data bits shifted so far in the current frame (0..DATA_BITS).
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse; frame accepted, downstream byte valid.
REQ-012 frame_err  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-014 State and counters SHALL advance only on cycles with baud_tick=1; outputs hold otherwise, except that pulses clear.
REQ-015 The FSM SHALL use states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: on a tick with rx_sync=0, go to START with tick_cnt=0.
REQ-017 START: increment tick_cnt on each tick; on the tick where tick_cnt=OVERSAMPLE/2-1, go to DATA if rx_sync=0, otherwise return to IDLE (glitch reject); tick_cnt resets to 0 and bit_cnt to 0.
REQ-018 DATA: increment tick_cnt on each tick; on the tick where tick_cnt=OVERSAMPLE-1, pulse shift_en with sample_bit=rx_sync, set tick_cnt to 0, and increment bit_cnt.
REQ-019 DATA: the shift that brings bit_cnt to DATA_BITS SHALL move the FSM to STOP.
REQ-020 Data bits SHALL be presented LSB first, in line order.
REQ-021 STOP: on the tick where tick_cnt=OVERSAMPLE-1, go to IDLE with a done pulse if rx_sync=1; otherwise pulse frame_err and go to BREAK.
REQ-022 BREAK: stay until a tick with rx_sync=1, then go to IDLE; no new start detection occurs in BREAK.
REQ-023 shift_en, done and frame_err SHALL be registered, exactly one clk wide, and never asserted together.
REQ-024 Exactly DATA_BITS shift_en pulses SHALL precede each done; an aborted start produces zero pulses.
REQ-025 tick_cnt width SHALL be $clog2(OVERSAMPLE); tick_cnt and bit_cnt never exceed their terminal values.
REQ-026 A start edge arriving in the same tick as STOP completion SHALL be detected on the next tick from IDLE.

Reset
REQ-027 Reset SHALL set: state IDLE, synchronizer flops 1, tick_cnt 0, bit_cnt 0, shift_en 0, sample_bit 0, done 0, frame_err 0, busy 0.
REQ-028 Reset SHALL dominate baud_tick; reset mid-frame SHALL discard the frame with no done or frame_err pulse.

Structure
REQ-029 Shared package uart_pkg SHALL hold the rx_state_e enum and OVERSAMPLE/DATA_BITS defaults.
REQ-030 The synchronizer SHALL be a sub-module, sync_2ff (clk, reset, d, q; reset value parameterised, 1 here).
REQ-031 The FSM SHALL be one state register with combinational next-state logic; no clock generated from baud_tick.

Verification
REQ-032 Send 0xA5 (baud_tick every 4 clk, OVERSAMPLE=16, valid stop) -> 8 shift_en pulses with sample_bit 1,0,1,0,0,1,0,1, then one done and frame_err=0.
REQ-033 Send a 0x55 frame with a low stop bit -> 8 shifts, frame_err pulse, no done, busy held until rx returns high.
REQ-034 Hold rx low for 5 ticks then high -> START aborts to IDLE, no shift_en, busy drops.
REQ-035 Send 0xFF then 0x00 back-to-back with a 1-bit stop -> two done pulses, with correct bit sequences.
REQ-036 Assert reset at bit 4 of 0x3C, then send 0xC3 -> no pulses from the aborted frame; 0xC3 received cleanly.
REQ-037 Run 0xA5 with baud_tick gaps of 1 to 7 clk randomly -> the same response as REQ-032.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default framing parameters
// and the receiver FSM state encoding.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit. The reset value
// is a parameter so that idle-high lines come out of reset in their idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q is the metastability-filtered copy of d.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller (8N1). Detects the start bit on the oversampled,
// synchronized line, samples each data bit at its midpoint and emits one
// shift_en pulse per bit, then a done or frame_err pulse on the stop bit.
// All state only moves on baud_tick cycles; pulses last one clk.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rx,
    output logic       shift_en,
    output logic       sample_bit,
    output logic [3:0] bit_cnt,
    output logic       busy,
    output logic       done,
    output logic       frame_err
);

    localparam int            TW         = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]    BIT_FINAL  = 4'(DATA_BITS - 1);

    logic          rx_sync;
    rx_state_e     state,      state_nxt;
    logic [TW-1:0] tick_cnt,   tick_nxt;
    logic [3:0]    bit_nxt;
    logic          sample_nxt;
    logic          shift_nxt;
    logic          done_nxt;
    logic          ferr_nxt;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_sync)
    );

    // Next-state and next-output logic; nothing moves without a baud tick.
    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick_cnt;
        bit_nxt    = bit_cnt;
        sample_nxt = sample_bit;
        shift_nxt  = 1'b0;
        done_nxt   = 1'b0;
        ferr_nxt   = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit in; a high level here is a glitch.
                    if (tick_cnt == TICK_HALF) begin
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = rx_sync ? IDLE : DATA;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt   = '0;
                        shift_nxt  = 1'b1;
                        sample_nxt = rx_sync;
                        bit_nxt    = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_FINAL) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt = '0;
                        if (rx_sync) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line before arming start detection again.
                    if (rx_sync) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            sample_bit <= 1'b0;
            shift_en   <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            sample_bit <= sample_nxt;
            shift_en   <= shift_nxt;
            done       <= done_nxt;
            frame_err  <= ferr_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames timed in baud ticks, records
// every output pulse as an event and compares against expected events queued
// while the frame is being driven.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int OS = 16;
    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       shift_en, sample_bit, busy, done, frame_err;
    logic [3:0] bit_cnt;

    // kind: 0 shift, 1 done, 2 frame_err, 3 overlapping pulses
    typedef struct packed {
        logic [1:0] kind;
        logic       val;
        logic [3:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  rand_gaps = 1'b0;

    uart_rx_ctrl #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .shift_en   (shift_en),
        .sample_bit (sample_bit),
        .bit_cnt    (bit_cnt),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Baud tick source: one-clk strobe every 4 clk, or every 1..7 clk at random.
    initial begin
        int gap;
        forever begin
            @(negedge clk);
            baud_tick = 1'b1;
            gap = rand_gaps ? int'($urandom_range(7, 1)) : 4;
            repeat (gap - 1) begin
                @(negedge clk);
                baud_tick = 1'b0;
            end
        end
    end

    // Output monitor: every pulse becomes one observed event.
    always @(negedge clk) begin
        if (!reset) begin
            if (int'(shift_en) + int'(done) + int'(frame_err) > 1)
                obs_q.push_back(ev_t'{2'd3, 1'b0, bit_cnt});
            else if (shift_en)
                obs_q.push_back(ev_t'{2'd0, sample_bit, bit_cnt});
            else if (done)
                obs_q.push_back(ev_t'{2'd1, 1'b0, bit_cnt});
            else if (frame_err)
                obs_q.push_back(ev_t'{2'd2, 1'b0, bit_cnt});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    task automatic wait_tick();
        do @(posedge clk); while (baud_tick !== 1'b1);
    endtask

    task automatic hold_line(input logic v, input int n);
        rx = v;
        repeat (n) wait_tick();
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        hold_line(1'b0, OS);
        for (int k = 0; k < NB; k++) begin
            exp_q.push_back(ev_t'{2'd0, d[k], 4'(k + 1)});
            hold_line(d[k], OS);
        end
        if (stop_v) exp_q.push_back(ev_t'{2'd1, 1'b0, 4'(NB)});
        else        exp_q.push_back(ev_t'{2'd2, 1'b0, 4'(NB)});
        hold_line(stop_v, OS);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if (shift_en !== 1'b0)   begin errors++; $display("FAIL rst_shift_en: got %b, expected 0", shift_en); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b, expected 0", done); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rst_frame_err: got %b, expected 0", frame_err); end
        checks++; if (bit_cnt !== 4'd0)    begin errors++; $display("FAIL rst_bit_cnt: got %0d, expected 0", bit_cnt); end
        checks++; if (sample_bit !== 1'b0) begin errors++; $display("FAIL rst_sample_bit: got %b, expected 0", sample_bit); end
        obs_q.delete();
    endtask

    task automatic test_single();
        ev_t e, o;
        hold_line(1'b1, 2 * OS);
        send_frame(8'hA5, 1'b1);
        hold_line(1'b1, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL a5_event: got none, expected %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL a5_event: got %h, expected %h", o, e); end end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL a5_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_idle: got %b, expected 0", busy); end
    endtask

    task automatic test_frame_err();
        ev_t e, o;
        send_frame(8'h55, 1'b0);
        hold_line(1'b0, OS);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b, expected 1", busy); end
        hold_line(1'b1, 4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b, expected 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL ferr_event: got none, expected %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL ferr_event: got %h, expected %h", o, e); end end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL ferr_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_glitch();
        hold_line(1'b1, 2 * OS);
        hold_line(1'b0, 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b, expected 1", busy); end
        hold_line(1'b0, 2);
        hold_line(1'b1, OS);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b, expected 0", busy); end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d events, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        hold_line(1'b1, OS);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        hold_line(1'b1, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_event: got none, expected %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL b2b_event: got %h, expected %h", o, e); end end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_midframe();
        ev_t e, o;
        logic [7:0] d;
        d = 8'h3C;
        hold_line(1'b1, OS);
        hold_line(1'b0, OS);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(ev_t'{2'd0, d[k], 4'(k + 1)});
            hold_line(d[k], OS);
        end
        rx = d[4];
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_bit_cnt: got %0d, expected 0", bit_cnt); end
        hold_line(1'b1, 2 * OS);
        send_frame(8'hC3, 1'b1);
        hold_line(1'b1, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL rstmid_event: got none, expected %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rstmid_event: got %h, expected %h", o, e); end end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_random_gaps();
        ev_t e, o;
        rand_gaps = 1'b1;
        hold_line(1'b1, OS);
        send_frame(8'hA5, 1'b1);
        hold_line(1'b1, 4);
        rand_gaps = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL rgap_event: got none, expected %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rgap_event: got %h, expected %h", o, e); end end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rgap_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rgap_busy_idle: got %b, expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
